// File: rtl/regfile_param_if.sv
// Register file access bundle: two read ports, two prioritised write ports, clear control.
// master drives addresses/writes/clear; slave returns read data, valid bits and busy.
interface regfile_param_if #(
  parameter int W     = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] Read1;
  logic [AW-1:0] Read2;
  logic [W-1:0]  Data1;
  logic [W-1:0]  Data2;
  logic          Valid1;
  logic          Valid2;
  logic          RegWriteA;
  logic [AW-1:0] WriteRegA;
  logic [W-1:0]  WriteDataA;
  logic          RegWriteB;
  logic [AW-1:0] WriteRegB;
  logic [W-1:0]  WriteDataB;
  logic          Clear;
  logic          Busy;

  modport master (
    output Read1, Read2, RegWriteA, WriteRegA, WriteDataA,
           RegWriteB, WriteRegB, WriteDataB, Clear,
    input  Data1, Data2, Valid1, Valid2, Busy
  );

  modport slave (
    input  Read1, Read2, RegWriteA, WriteRegA, WriteDataA,
           RegWriteB, WriteRegB, WriteDataB, Clear,
    output Data1, Data2, Valid1, Valid2, Busy
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/2W register file with per-entry valid bits and a one-entry-per-cycle clear sweep.
// Latency: reads combinational, writes visible next cycle (same cycle with RF_BYPASS_EN defined).
// Backpressure: none; writes and Clear presented while Busy are dropped, not queued.
module regfile_param #(
  parameter int W        = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_param_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic              busy_q;
  logic [W-1:0]      mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic wr_ok(input logic en, input logic [AW-1:0] a);
    return en && !is_zero_reg(a);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      vld    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // B first so a same-address A write overrides it
          if (wr_ok(bus.RegWriteB, bus.WriteRegB)) begin
            mem[bus.WriteRegB] <= bus.WriteDataB;
            vld[bus.WriteRegB] <= 1'b1;
          end
          if (wr_ok(bus.RegWriteA, bus.WriteRegA)) begin
            mem[bus.WriteRegA] <= bus.WriteDataA;
            vld[bus.WriteRegA] <= 1'b1;
          end
          busy_q <= bus.Clear;
          if (bus.Clear) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          vld[cnt] <= 1'b0;
          cnt      <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Returns {valid, data} for one read port
  function automatic logic [W:0] read_port(input logic [AW-1:0] ra);
    logic [W-1:0] d;
    logic         v;
    d = mem[ra];
    v = vld[ra];
`ifdef RF_BYPASS_EN
    if (state == IDLE) begin
      if (wr_ok(bus.RegWriteB, bus.WriteRegB) && bus.WriteRegB == ra) begin
        d = bus.WriteDataB;
        v = 1'b1;
      end
      if (wr_ok(bus.RegWriteA, bus.WriteRegA) && bus.WriteRegA == ra) begin
        d = bus.WriteDataA;
        v = 1'b1;
      end
    end
`endif
    if (is_zero_reg(ra)) begin
      d = '0;
      v = 1'b1;
    end
    return {v, d};
  endfunction

  logic [W:0] rd1;
  logic [W:0] rd2;

  always_comb begin
    rd1 = read_port(bus.Read1);
    rd2 = read_port(bus.Read2);
  end

  assign bus.Data1  = rd1[W-1:0];
  assign bus.Valid1 = rd1[W];
  assign bus.Data2  = rd2[W-1:0];
  assign bus.Valid2 = rd2[W];
  assign bus.Busy   = busy_q;
endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param against an array model, plus directed literal checks.
module tb_regfile_param;
  localparam int W     = 32;
  localparam int DEPTH = 32;
  localparam int ZR    = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_param_if #(.W(W), .DEPTH(DEPTH)) bus();

  regfile_param #(.W(W), .DEPTH(DEPTH), .ZERO_REG(ZR)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: contents, valid flags, and number of sweep cycles still to run
  logic [W-1:0] m_mem [DEPTH];
  logic         m_vld [DEPTH];
  int           busy_left;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] exp_rd(input logic [4:0] a);
    logic [W-1:0] d;
    logic         v;
    d = m_mem[a];
    v = m_vld[a];
`ifdef RF_BYPASS_EN
    if (busy_left == 0) begin
      if (bus.RegWriteA && bus.WriteRegA == a) begin
        d = bus.WriteDataA;
        v = 1'b1;
      end else if (bus.RegWriteB && bus.WriteRegB == a) begin
        d = bus.WriteDataB;
        v = 1'b1;
      end
    end
`endif
    if (ZR == 1 && a == 5'd0) begin
      d = '0;
      v = 1'b1;
    end
    return {v, d};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_vld[i] = 1'b0;
      end
      busy_left = 0;
    end else if (busy_left > 0) begin
      m_mem[DEPTH - busy_left] = '0;
      m_vld[DEPTH - busy_left] = 1'b0;
      busy_left--;
    end else begin
      if (bus.RegWriteA && !(ZR == 1 && bus.WriteRegA == 5'd0)) begin
        m_mem[bus.WriteRegA] = bus.WriteDataA;
        m_vld[bus.WriteRegA] = 1'b1;
      end
      if (bus.RegWriteB && !(ZR == 1 && bus.WriteRegB == 5'd0) &&
          !(bus.RegWriteA && bus.WriteRegA == bus.WriteRegB)) begin
        m_mem[bus.WriteRegB] = bus.WriteDataB;
        m_vld[bus.WriteRegB] = 1'b1;
      end
      if (bus.Clear) busy_left = DEPTH;
    end
  end

  always @(negedge clk) begin
    chk("port1", {31'd0, bus.Valid1, bus.Data1}, {31'd0, exp_rd(bus.Read1)});
    chk("port2", {31'd0, bus.Valid2, bus.Data2}, {31'd0, exp_rd(bus.Read2)});
    chk("busy", {63'd0, bus.Busy}, {63'd0, busy_left > 0});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.RegWriteA  = 1'b0;
    bus.WriteRegA  = '0;
    bus.WriteDataA = '0;
    bus.RegWriteB  = 1'b0;
    bus.WriteRegB  = '0;
    bus.WriteDataB = '0;
    bus.Clear      = 1'b0;
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [W-1:0] d);
    bus.RegWriteA  = 1'b1;
    bus.WriteRegA  = a;
    bus.WriteDataA = d;
  endtask

  task automatic fill();
    for (int r = 1; r < DEPTH; r++) begin
      step();
      idle_in();
      wr_a(5'(r), $urandom | 32'h1);
    end
    step();
    idle_in();
  endtask

  initial begin
    int nb;
    idle_in();
    bus.Read1 = '0;
    bus.Read2 = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
    rst_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) begin
      step();
      bus.Read1 = 5'(a);
      bus.Read2 = 5'(DEPTH - 1 - a);
      @(negedge clk);
      chk("rst_data", {32'd0, bus.Data1}, 64'd0);
      chk("rst_valid", {63'd0, bus.Valid1}, (a == 0) ? 64'd1 : 64'd0);
    end

    step(); wr_a(5'd1, 32'hA5A5A5A5);
    step(); idle_in(); bus.Read1 = 5'd1; bus.Read2 = 5'd3;
    @(negedge clk);
    chk("wrA_data", {32'd0, bus.Data1}, 64'hA5A5A5A5);
    chk("wrA_valid", {63'd0, bus.Valid1}, 64'd1);
    chk("r3_empty", {31'd0, bus.Valid2, bus.Data2}, 64'd0);

    step(); wr_a(5'd2, 32'h5A5A5A5A);
    bus.RegWriteB = 1'b1; bus.WriteRegB = 5'd2; bus.WriteDataB = 32'hDEADBEEF;
    step(); idle_in();
    wr_a(5'd5, 32'h1);
    bus.RegWriteB = 1'b1; bus.WriteRegB = 5'd6; bus.WriteDataB = 32'h2;
    bus.Read2 = 5'd2;
    @(negedge clk);
    chk("prio_A", {32'd0, bus.Data2}, 64'h5A5A5A5A);
    step(); idle_in(); bus.Read1 = 5'd5; bus.Read2 = 5'd6;
    @(negedge clk);
    chk("dual5", {32'd0, bus.Data1}, 64'h1);
    chk("dual6", {32'd0, bus.Data2}, 64'h2);

    step(); wr_a(5'd0, 32'hFFFFFFFF); bus.Read1 = 5'd0;
    step(); idle_in();
    @(negedge clk);
    chk("zero_reg", {32'd0, bus.Data1}, 64'd0);

    step(); wr_a(5'd4, 32'h12345678); bus.Read1 = 5'd4;
    @(negedge clk);
`ifdef RF_BYPASS_EN
    chk("bypass", {32'd0, bus.Data1}, 64'h12345678);
`else
    chk("no_bypass", {32'd0, bus.Data1}, 64'd0);
`endif
    step(); idle_in();
    @(negedge clk);
    chk("wr4_next", {32'd0, bus.Data1}, 64'h12345678);

    fill();
    bus.Clear = 1'b1;
    step(); bus.Clear = 1'b0;
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.Busy) break;
      nb++;
      step();
      idle_in();
      if (i == 10) wr_a(5'd7, 32'hCAFEF00D);
    end
    chk("busy_len", 64'(nb), 64'd32);
    for (int a = 0; a < DEPTH; a++) begin
      step();
      bus.Read1 = 5'(a);
      @(negedge clk);
      chk("cleared", {31'd0, bus.Valid1, bus.Data1}, (a == 0) ? {31'd0, 1'b1, 32'd0} : 64'd0);
    end

    fill();
    bus.Read1 = 5'd1;
    bus.Clear = 1'b1;
    step(); bus.Clear = 1'b0;
    repeat (10) step();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bus.Busy}, 64'd0);
    chk("abort_data", {32'd0, bus.Data1}, 64'd0);
    step(); rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      step();
      rst_n          = ($urandom_range(0, 599) != 0);
      bus.RegWriteA  = $urandom_range(0, 1) == 1;
      bus.WriteRegA  = 5'($urandom);
      bus.WriteDataA = $urandom;
      bus.RegWriteB  = $urandom_range(0, 1) == 1;
      bus.WriteRegB  = ($urandom_range(0, 3) == 0) ? bus.WriteRegA : 5'($urandom);
      bus.WriteDataB = $urandom;
      bus.Clear      = ($urandom_range(0, 39) == 0);
      bus.Read1      = ($urandom_range(0, 3) == 0) ? bus.WriteRegA : 5'($urandom);
      bus.Read2      = ($urandom_range(0, 3) == 0) ? bus.WriteRegB : 5'($urandom);
    end
    step();
    idle_in();
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
